// File: rtl/config_ctrl_burst_if.sv
// config_ctrl_burst_if: request, reply and configurator bus of the burst config controller.
// Ports: none; signals grouped as
//   request : spk_in_config_we, spk_in_config_wdata, config_spk_in_credit
//   arbiter : axon_busy, work_config_busy
//   reply   : config_spk_out_we, config_spk_out_wdata, spk_out_config_full, config_err
//   config  : config_we, config_waddr, config_wdata, config_re, config_raddr, config_rdata
// master = controller side, slave = node side.
interface config_ctrl_burst_if #(
    parameter int FW  = 59,
    parameter int CDW = 21,
    parameter int CAW = 15
) ();
    logic           spk_in_config_we;
    logic [FW-1:0]  spk_in_config_wdata;
    logic           config_spk_in_credit;
    logic           axon_busy;
    logic           work_config_busy;
    logic           config_spk_out_we;
    logic [FW-1:0]  config_spk_out_wdata;
    logic           spk_out_config_full;
    logic           config_err;
    logic           config_we;
    logic [CAW-1:0] config_waddr;
    logic [CDW-1:0] config_wdata;
    logic           config_re;
    logic [CAW-1:0] config_raddr;
    logic [CDW-1:0] config_rdata;

    modport master (
        input  spk_in_config_we, spk_in_config_wdata, axon_busy, work_config_busy,
               spk_out_config_full, config_rdata,
        output config_spk_in_credit, config_spk_out_we, config_spk_out_wdata, config_err,
               config_we, config_waddr, config_wdata, config_re, config_raddr
    );

    modport slave (
        output spk_in_config_we, spk_in_config_wdata, axon_busy, work_config_busy,
               spk_out_config_full, config_rdata,
        input  config_spk_in_credit, config_spk_out_we, config_spk_out_wdata, config_err,
               config_we, config_waddr, config_wdata, config_re, config_raddr
    );
endinterface

// File: rtl/config_ctrl_burst.sv
// config_ctrl_burst: node configuration controller with burst reads and reply routing.
// Ports:
//   clk    - clock
//   rst_n  - asynchronous active-low reset
//   io_bus - config_ctrl_burst_if.master: request in/credit, busy inputs,
//            reply flit out, drop error, configurator read/write port
module config_ctrl_burst #(
    parameter int FW    = 59,
    parameter int FTW   = 3,
    parameter int ATW   = 3,
    parameter int CDW   = 21,
    parameter int CAW   = 15,
    parameter int XW    = 4,
    parameter int YW    = 4,
    parameter int LW    = 4,
    parameter int R_FLG = 36,
    parameter int X_FLG = R_FLG + 12
) (
    input logic                 clk,
    input logic                 rst_n,
    config_ctrl_burst_if.master io_bus
);
    localparam logic [FTW-1:0] T_WRITE    = 3'b110;
    localparam logic [FTW-1:0] T_READ     = 3'b111;
    localparam logic [FTW-1:0] T_DATA     = 3'b001;
    localparam logic [FTW-1:0] T_DATA_END = 3'b010;
    localparam logic [ATW-1:0] C_WGT      = 3'b001;
    localparam logic [ATW-1:0] C_DST      = 3'b010;
    localparam logic [ATW-1:0] C_VM       = 3'b100;
    localparam logic [ATW-1:0] C_VMBUF    = 3'b110;

    typedef enum logic [2:0] {IDLE, W_WAIT, R_READ, R_WAIT, R_SEND} state_t;

    state_t            r_cs, w_ns;
    logic [CAW-1:0]    r_waddr, r_raddr;
    logic [CDW-1:0]    r_wdata;
    logic [XW+YW-1:0]  r_xy;
    logic [LW-1:0]     r_cnt;
    logic              r_single, r_err;
    logic [FW-1:0]     r_reply;
    logic [FTW-1:0]    w_type, w_rtype;
    logic [CAW-1:0]    w_addr;
    logic [CDW-1:0]    w_data;
    logic              w_wblk, w_rblk, w_we, w_re, w_out_we, w_credit, w_unused;

    // Classes not listed fall through as CFG_REG, i.e. never blocked.
    function automatic logic blocked(input logic [ATW-1:0] c, input logic ab, input logic wb);
        return ((c == C_WGT || c == C_VMBUF) && ab) || ((c == C_DST || c == C_VM) && wb);
    endfunction

    assign w_type   = io_bus.spk_in_config_wdata[FW-1:FW-FTW];
    assign w_addr   = io_bus.spk_in_config_wdata[CDW+CAW-1:CDW];
    assign w_data   = io_bus.spk_in_config_wdata[CDW-1:0];
    assign w_unused = ^io_bus.spk_in_config_wdata[FW-FTW-1:CDW+CAW];
    assign w_wblk   = blocked(r_waddr[CAW-1:CAW-ATW], io_bus.axon_busy, io_bus.work_config_busy);
    assign w_rblk   = blocked(r_raddr[CAW-1:CAW-ATW], io_bus.axon_busy, io_bus.work_config_busy);
    // A single-word read answers with type READ; bursts mark their last word DATA_END.
    assign w_rtype  = r_single ? T_READ : (r_cnt == '0 ? T_DATA_END : T_DATA);

    always_comb begin
        w_ns     = r_cs;
        w_we     = 1'b0;
        w_re     = 1'b0;
        w_out_we = 1'b0;
        w_credit = r_err;
        case (r_cs)
            IDLE:    if (io_bus.spk_in_config_we)
                         w_ns = w_type == T_WRITE ? W_WAIT : (w_type == T_READ ? R_READ : IDLE);
            W_WAIT:  if (!w_wblk) begin
                         w_we     = 1'b1;
                         w_credit = 1'b1;
                         w_ns     = IDLE;
                     end
            R_READ:  if (!w_rblk) begin
                         w_re = 1'b1;
                         w_ns = R_WAIT;
                     end
            R_WAIT:  w_ns = R_SEND;
            R_SEND:  if (!io_bus.spk_out_config_full && !io_bus.work_config_busy) begin
                         w_out_we = 1'b1;
                         w_credit = r_cnt == '0;
                         w_ns     = r_cnt == '0 ? IDLE : R_READ;
                     end
            default: w_ns = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cs     <= IDLE;
            r_waddr  <= '0;
            r_wdata  <= '0;
            r_raddr  <= '0;
            r_xy     <= '0;
            r_cnt    <= '0;
            r_single <= 1'b0;
            r_err    <= 1'b0;
            r_reply  <= '0;
        end else begin
            r_cs  <= w_ns;
            r_err <= 1'b0;
            case (r_cs)
                IDLE:    if (io_bus.spk_in_config_we) begin
                             if (w_type == T_WRITE) begin
                                 r_waddr <= w_addr;
                                 r_wdata <= w_data;
                             end else if (w_type == T_READ) begin
                                 r_raddr  <= w_addr;
                                 r_xy     <= w_data[CDW-1:CDW-XW-YW];
                                 r_cnt    <= w_data[LW-1:0];
                                 r_single <= w_data[LW-1:0] == '0;
                             end else begin
                                 r_err <= 1'b1;
                             end
                         end
                R_WAIT:  r_reply <= {w_rtype, r_xy, {(X_FLG-R_FLG){1'b0}}, r_raddr, io_bus.config_rdata};
                // Next burst word: address wraps inside its class.
                R_SEND:  if (w_out_we && r_cnt != '0) begin
                             r_cnt   <= r_cnt - 1'b1;
                             r_raddr <= {r_raddr[CAW-1:CAW-ATW], r_raddr[CAW-ATW-1:0] + 1'b1};
                         end
                W_WAIT, R_READ: ;
                default: begin
                             r_waddr  <= '0;
                             r_wdata  <= '0;
                             r_raddr  <= '0;
                             r_xy     <= '0;
                             r_cnt    <= '0;
                             r_single <= 1'b0;
                             r_reply  <= '0;
                         end
            endcase
        end
    end

    assign io_bus.config_we            = w_we;
    assign io_bus.config_re            = w_re;
    assign io_bus.config_spk_out_we    = w_out_we;
    assign io_bus.config_spk_in_credit = w_credit;
    assign io_bus.config_err           = r_err;
    assign io_bus.config_waddr         = r_waddr;
    assign io_bus.config_wdata         = r_wdata;
    assign io_bus.config_raddr         = r_raddr;
    assign io_bus.config_spk_out_wdata = r_reply;
endmodule
